dcache_wb2: RTL

- Two-way set-associative, write-back, write-allocate data cache between the RV64I core's load/store stage and the data memory (dm).
- Single-word (64-bit) lines.
- Provides a flush sequence so that, at program end, every dirty line is committed to dm before results are compared against golden data.
- Instanced in Top as "Dcache".

---
 rtl/dcache_pkg.sv | 34 +++
 rtl/dcache_way.sv | 61 ++++++
 rtl/dcache_wb2.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// Shared types and helpers for the two-way write-back data cache.
// Geometry derivation and byte-lane merge live here so way and top agree.
package dcache_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWb,
        StRefill,
        StFlushScan,
        StFlushWb,
        StFlushDone
    } state_e;

    localparam int unsigned OFFSET_W = 3;

    function automatic int unsigned index_w(input int unsigned sets);
        return $clog2(sets);
    endfunction

    function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned sets);
        return addr_w - OFFSET_W - $clog2(sets);
    endfunction

    function automatic logic [63:0] byte_merge(input logic [7:0]  wstrb,
                                               input logic [63:0] old_data,
                                               input logic [63:0] new_data);
        logic [63:0] merged;
        for (int i = 0; i < 8; i++) begin
            merged[8*i +: 8] = wstrb[i] ? new_data[8*i +: 8] : old_data[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/dcache_way.sv
// One cache way: per-set valid/dirty/tag/data with an async read port and
// a write port that either fills a whole line, byte-merges a store, or cleans.
module dcache_way
    import dcache_pkg::*;
#(
    parameter int unsigned SETS    = 32,
    parameter int unsigned TAG_W   = 56,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned INDEX_W = index_w(SETS)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [INDEX_W-1:0] rd_idx_i,
    output logic               rd_valid_o,
    output logic [TAG_W-1:0]   rd_tag_o,
    input  logic               fill_i,
    input  logic               store_i,
    input  logic               clean_i,
    input  logic [INDEX_W-1:0] wr_idx_i,
    input  logic [TAG_W-1:0]   wr_tag_i,
    input  logic [DATA_W-1:0]  wr_data_i,
    input  logic [7:0]         wr_strb_i,
    output logic [DATA_W-1:0]  mem_o [SETS],
    output logic [SETS-1:0]    dirty_o
);

    logic [SETS-1:0]   valid_q;
    logic [SETS-1:0]   dirty_q;
    logic [TAG_W-1:0]  tag_q [SETS];
    logic [DATA_W-1:0] mem_q [SETS];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_i) begin
            valid_q[wr_idx_i] <= 1'b1;
            dirty_q[wr_idx_i] <= 1'b0;
        end else if (store_i) begin
            dirty_q[wr_idx_i] <= 1'b1;
        end else if (clean_i) begin
            dirty_q[wr_idx_i] <= 1'b0;
        end
    end

    // Tag and data storage is deliberately left uncleared by reset.
    always_ff @(posedge clk_i) begin
        if (fill_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
            tag_q[wr_idx_i] <= wr_tag_i;
        end else if (store_i) begin
            mem_q[wr_idx_i] <= byte_merge(wr_strb_i, mem_q[wr_idx_i], wr_data_i);
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign mem_o      = mem_q;
    assign dirty_o    = dirty_q;

endmodule

// File: rtl/dcache_wb2.sv
// Two-way set-associative write-back/write-allocate data cache, one 64-bit
// word per line, with a full-cache flush walk that commits every dirty line.
module dcache_wb2
    import dcache_pkg::*;
#(
    parameter int unsigned SETS   = 32,
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [7:0]        cpu_wstrb,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    input  logic              flush_req,
    output logic              flush_done
);

    localparam int unsigned INDEX_W = index_w(SETS);
    localparam int unsigned TAG_W   = tag_w(ADDR_W, SETS);
    localparam int unsigned SCAN_W  = INDEX_W + 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = {SCAN_W{1'b1}};

    state_e            state_q;
    logic [SCAN_W-1:0] scan_q;
    logic [SETS-1:0]   lru_q;
    logic              victim_q;
    logic              flush_armed_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              flush_done_q;

    // Per-way storage aliases, visible by name through the hierarchy.
    logic [DATA_W-1:0] mem1 [SETS];
    logic [DATA_W-1:0] mem2 [SETS];
    logic [SETS-1:0]   dirty1;
    logic [SETS-1:0]   dirty2;

    logic [INDEX_W-1:0] cpu_idx;
    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   cpu_tag;
    logic [TAG_W-1:0]   way1_tag;
    logic [TAG_W-1:0]   way2_tag;
    logic               way1_valid;
    logic               way2_valid;
    logic               in_flush;
    logic               hit1;
    logic               hit2;
    logic               hit;
    logic               miss_way;
    logic               sel_way;
    logic               sel_valid;
    logic               sel_dirty;
    logic [TAG_W-1:0]   sel_tag;
    logic [DATA_W-1:0]  sel_data;
    logic [1:0]         fill_en;
    logic [1:0]         store_en;
    logic [1:0]         clean_en;
    logic [DATA_W-1:0]  wr_data;
    logic               unused_offset;

    assign cpu_idx       = cpu_addr[INDEX_W+OFFSET_W-1:OFFSET_W];
    assign cpu_tag       = cpu_addr[ADDR_W-1:INDEX_W+OFFSET_W];
    assign unused_offset = ^cpu_addr[OFFSET_W-1:0];
    assign in_flush      = (state_q == StFlushScan) || (state_q == StFlushWb);
    assign idx           = in_flush ? scan_q[SCAN_W-1:1] : cpu_idx;

    assign hit1 = way1_valid && (way1_tag == cpu_tag);
    assign hit2 = way2_valid && (way2_tag == cpu_tag);
    assign hit  = (state_q == StIdle) && cpu_req && (hit1 || hit2);

    assign cpu_ready = hit;
    assign cpu_rdata = hit2 ? mem2[idx] : mem1[idx];

    // One mux serves both the miss victim and the flush scan entry.
    always_comb begin
        if (!way1_valid) begin
            miss_way = 1'b0;
        end else if (!way2_valid) begin
            miss_way = 1'b1;
        end else begin
            miss_way = lru_q[cpu_idx];
        end
        sel_way   = in_flush ? scan_q[0] : miss_way;
        sel_valid = sel_way ? way2_valid : way1_valid;
        sel_dirty = sel_way ? dirty2[idx] : dirty1[idx];
        sel_tag   = sel_way ? way2_tag : way1_tag;
        sel_data  = sel_way ? mem2[idx] : mem1[idx];
    end

    always_comb begin
        fill_en  = '0;
        store_en = '0;
        clean_en = '0;
        if (!rst) begin
            if (hit && cpu_we) begin
                store_en[hit2] = 1'b1;
            end
            if (mem_ready) begin
                case (state_q)
                    StWb:      clean_en[victim_q]  = 1'b1;
                    StRefill:  fill_en[victim_q]   = 1'b1;
                    StFlushWb: clean_en[scan_q[0]] = 1'b1;
                    default:   ;
                endcase
            end
        end
    end

    assign wr_data = (state_q == StRefill) ? mem_rdata : cpu_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            scan_q        <= '0;
            lru_q         <= '0;
            victim_q      <= 1'b0;
            flush_armed_q <= 1'b1;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            flush_done_q  <= 1'b0;
        end else begin
            flush_done_q <= 1'b0;
            if (!flush_req) begin
                flush_armed_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (cpu_req) begin
                        if (hit) begin
                            lru_q[cpu_idx] <= ~hit2;
                        end else begin
                            victim_q  <= miss_way;
                            mem_req_q <= 1'b1;
                            if (sel_valid && sel_dirty) begin
                                state_q     <= StWb;
                                mem_we_q    <= 1'b1;
                                mem_addr_q  <= {sel_tag, cpu_idx, {OFFSET_W{1'b0}}};
                                mem_wdata_q <= sel_data;
                            end else begin
                                state_q    <= StRefill;
                                mem_we_q   <= 1'b0;
                                mem_addr_q <= {cpu_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                            end
                        end
                    end else if (flush_req && flush_armed_q) begin
                        state_q       <= StFlushScan;
                        scan_q        <= '0;
                        flush_armed_q <= 1'b0;
                    end
                end
                StWb: begin
                    if (mem_ready) begin
                        state_q    <= StRefill;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= {cpu_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                    end
                end
                StRefill: begin
                    if (mem_ready) begin
                        state_q   <= StIdle;
                        mem_req_q <= 1'b0;
                    end
                end
                StFlushScan: begin
                    if (sel_valid && sel_dirty) begin
                        state_q     <= StFlushWb;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= {sel_tag, idx, {OFFSET_W{1'b0}}};
                        mem_wdata_q <= sel_data;
                    end else if (scan_q == SCAN_LAST) begin
                        state_q      <= StFlushDone;
                        flush_done_q <= 1'b1;
                    end else begin
                        scan_q <= scan_q + 1'b1;
                    end
                end
                StFlushWb: begin
                    if (mem_ready) begin
                        mem_req_q <= 1'b0;
                        if (scan_q == SCAN_LAST) begin
                            state_q      <= StFlushDone;
                            flush_done_q <= 1'b1;
                        end else begin
                            state_q <= StFlushScan;
                            scan_q  <= scan_q + 1'b1;
                        end
                    end
                end
                StFlushDone: state_q <= StIdle;
                default:     state_q <= StIdle;
            endcase
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign flush_done = flush_done_q;

    dcache_way #(
        .SETS   (SETS),
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W),
        .INDEX_W(INDEX_W)
    ) u_way1 (
        .clk_i     (clk),
        .rst_i     (rst),
        .rd_idx_i  (idx),
        .rd_valid_o(way1_valid),
        .rd_tag_o  (way1_tag),
        .fill_i    (fill_en[0]),
        .store_i   (store_en[0]),
        .clean_i   (clean_en[0]),
        .wr_idx_i  (idx),
        .wr_tag_i  (cpu_tag),
        .wr_data_i (wr_data),
        .wr_strb_i (cpu_wstrb),
        .mem_o     (mem1),
        .dirty_o   (dirty1)
    );

    dcache_way #(
        .SETS   (SETS),
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W),
        .INDEX_W(INDEX_W)
    ) u_way2 (
        .clk_i     (clk),
        .rst_i     (rst),
        .rd_idx_i  (idx),
        .rd_valid_o(way2_valid),
        .rd_tag_o  (way2_tag),
        .fill_i    (fill_en[1]),
        .store_i   (store_en[1]),
        .clean_i   (clean_en[1]),
        .wr_idx_i  (idx),
        .wr_tag_i  (cpu_tag),
        .wr_data_i (wr_data),
        .wr_strb_i (cpu_wstrb),
        .mem_o     (mem2),
        .dirty_o   (dirty2)
    );

endmodule
